// File: rtl/imem_responder.sv
// Instruction-memory responder: word-organised instruction store read by fetch requests.
// Latency: LATENCY cycles from request accept to rsp_valid, in order, one word per request.
// Backpressure: req_ready drops once LATENCY+1 requests are outstanding; responses wait in a FIFO.
//
// Ports:
//   clk, reset                    - single clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr  - fetch request channel (byte address)
//   rsp_valid/rsp_ready           - response channel handshake
//   rsp_instr/rsp_error           - instruction word, error flag for misaligned/out-of-range fetches
//   load_en/load_addr/load_data   - side-band store write port (program loading)
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_error,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int CAP = LATENCY + 1;
  // CAP is at most 5, so an 8-entry FIFO always has room for every outstanding request.
  localparam int FD  = 8;
  localparam int PW  = 3;
  localparam int CW  = 4;
  localparam int OW  = 3;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic req_acc;
  logic rsp_pop;
  assign req_acc = req_valid && req_ready;
  assign rsp_pop = rsp_valid && rsp_ready;

  // Request decode and store read (value captured at the acceptance edge)
  logic [AW-1:0] req_idx;
  logic          req_ok;
  logic [31:0]   rd_dat;
  logic          rd_err;
  assign req_idx = req_addr[AW+1:2];
  assign req_ok  = (req_addr[1:0] == 2'b00) && (req_addr[31:AW+2] == '0);
  assign rd_dat  = req_ok ? mem_q[req_idx] : NOP_INSTR;
  assign rd_err  = !req_ok;

  // Load port; the read above sees pre-edge contents, so a same-edge load returns old data.
  logic [AW-1:0] ld_idx;
  logic          ld_ok;
  assign ld_idx = load_addr[AW+1:2];
  assign ld_ok  = (load_addr[1:0] == 2'b00) && (load_addr[31:AW+2] == '0);

  always_ff @(posedge clk) begin
    if (load_en && ld_ok) begin
      mem_q[ld_idx] <= load_data;
    end
  end

  // Read pipeline: LATENCY-1 register stages between the acceptance edge and the FIFO write.
  logic        wr_vld;
  logic [31:0] wr_dat;
  logic        wr_err;

  generate
    if (LATENCY == 1) begin : g_nopipe
      assign wr_vld = req_acc;
      assign wr_dat = rd_dat;
      assign wr_err = rd_err;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0] vld_q;
      logic [NS-1:0] err_q;
      logic [31:0]   dat_q [NS];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= req_acc;
          for (int i = 1; i < NS; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        dat_q[0] <= rd_dat;
        err_q[0] <= rd_err;
        for (int i = 1; i < NS; i++) begin
          dat_q[i] <= dat_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end

      assign wr_vld = vld_q[NS-1];
      assign wr_dat = dat_q[NS-1];
      assign wr_err = err_q[NS-1];
    end
  endgenerate

  // In-order response FIFO and outstanding counter
  logic [31:0]   fifo_dat_q [FD];
  logic [FD-1:0] fifo_err_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    if (wr_vld) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rsp_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_vld && !rsp_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!wr_vld && rsp_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (req_acc && !rsp_pop) begin
      out_d = out_q + OW'(1);
    end else if (!req_acc && rsp_pop) begin
      out_d = out_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      fifo_dat_q[wr_ptr_q] <= wr_dat;
      fifo_err_q[wr_ptr_q] <= wr_err;
    end
  end

  // Outputs come from registered state only; the head is forced to zero when empty.
  assign req_ready = (out_q < OW'(CAP));
  assign rsp_valid = (cnt_q != '0);
  assign rsp_instr = rsp_valid ? fifo_dat_q[rd_ptr_q] : '0;
  assign rsp_error = rsp_valid ? fifo_err_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  typedef logic [32:0] exp_t;  // {error, instr}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] model_mem [256];
  logic [31:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference store: a load lands at the rising edge, after the negedge push that used old data.
  always @(posedge clk) begin
    if (load_en && load_addr[1:0] == 2'b00 && load_addr[31:10] == '0)
      model_mem[load_addr[9:2]] = load_data;
  end

  function automatic exp_t expect_of(logic [31:0] a);
    if (a[1:0] != 2'b00 || a[31:10] != '0) return {1'b1, 32'h0000_0013};
    return {1'b0, model_mem[a[9:2]]};
  endfunction

  // Three responders share stimulus: index 0 is LATENCY=2, 1 is LATENCY=1, 2 is LATENCY=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LATG = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic        rdy, vld, err;
    logic [31:0] instr;
    exp_t        q[$];
    int          n_rsp = 0;
    int          n_acc = 0;

    imem_responder #(.DEPTH_WORDS(256), .LATENCY(LATG), .NOP_INSTR(32'h0000_0013)) u_dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(rdy), .req_addr(req_addr),
      .rsp_valid(vld), .rsp_ready(rsp_ready), .rsp_instr(instr), .rsp_error(err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
      if (rst_n) begin
        total++;
        if (rdy !== (q.size() < LATG + 1)) begin
          bad++;
          $display("FAIL ready_L%0d cyc=%0d: got %b want %b (outstanding %0d)", LATG, cyc, rdy, (q.size() < LATG + 1), q.size());
        end
        if (vld === 1'b1) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL spurious_rsp_L%0d cyc=%0d: got rsp_valid=1 want 0 (nothing outstanding)", LATG, cyc);
          end else begin
            if ({err, instr} !== q[0]) begin
              bad++;
              $display("FAIL rsp_data_L%0d cyc=%0d: got err=%b instr=%h want err=%b instr=%h", LATG, cyc, err, instr, q[0][32], q[0][31:0]);
            end
            if (rsp_ready) begin
              void'(q.pop_front());
              n_rsp++;
            end
          end
        end
        if (req_valid && rdy === 1'b1) begin
          q.push_back(expect_of(req_addr));
          n_acc++;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(negedge clk);
    total++; if (g_dut[0].rdy !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", g_dut[0].rdy); end
    total++; if (g_dut[0].vld !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", g_dut[0].vld); end
    total++; if (g_dut[0].instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", g_dut[0].instr); end
    total++; if (g_dut[0].err !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", g_dut[0].err); end
    rst_n = 1'b1;
  endtask

  task automatic init_store();
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = 32'(i * 4); load_data = $urandom;
    end
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e;
    int first[3];
    int last0, nv0;
    first = '{-1, -1, -1}; last0 = -1; nv0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = 32'(i * 4); load_data = prog[i];
    end
    @(posedge clk); #1;
    load_en = 1'b0; rsp_ready = 1'b1;
    e = cyc + 1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          req_valid = 1'b1; req_addr = 32'(i * 4);
          @(posedge clk); #1;
        end
        req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (first[0] < 0 && g_dut[0].vld === 1'b1) first[0] = cyc;
          if (first[1] < 0 && g_dut[1].vld === 1'b1) first[1] = cyc;
          if (first[2] < 0 && g_dut[2].vld === 1'b1) first[2] = cyc;
          if (g_dut[0].vld === 1'b1) begin nv0++; last0 = cyc; end
        end
      end
    join
    total++; if (first[0] != e + 1) begin bad++; $display("FAIL latency_L2: got cycle %0d want %0d", first[0], e + 1); end
    total++; if (first[1] != e)     begin bad++; $display("FAIL latency_L1: got cycle %0d want %0d", first[1], e); end
    total++; if (first[2] != e + 3) begin bad++; $display("FAIL latency_L4: got cycle %0d want %0d", first[2], e + 3); end
    total++; if (nv0 != 4 || last0 - first[0] != 3) begin bad++; $display("FAIL no_bubbles: got %0d valid cycles span %0d want 4 span 3", nv0, last0 - first[0]); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic [31:0] got_i [3];
    logic        got_e [3];
    int n;
    addrs = '{32'h2, 32'h400, 32'h4};
    n = 0;
    rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          req_valid = 1'b1; req_addr = addrs[i];
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (g_dut[0].vld === 1'b1 && n < 3) begin got_i[n] = g_dut[0].instr; got_e[n] = g_dut[0].err; n++; end
        end
      end
    join
    total++;
    if (n != 3) begin bad++; $display("FAIL err_count: got %0d responses want 3", n); end
    else begin
      if (got_i[0] !== 32'h13 || got_e[0] !== 1'b1) begin bad++; $display("FAIL err_misaligned: got %h/%b want 00000013/1", got_i[0], got_e[0]); end
      total++;
      if (got_i[1] !== 32'h13 || got_e[1] !== 1'b1) begin bad++; $display("FAIL err_range: got %h/%b want 00000013/1", got_i[1], got_e[1]); end
      total++;
      if (got_i[2] !== prog[1] || got_e[2] !== 1'b0) begin bad++; $display("FAIL err_ok_after: got %h/%b want %h/0", got_i[2], got_e[2], prog[1]); end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [31:0] head;
    acc = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'(i * 4);
      @(negedge clk);
      if (g_dut[0].rdy === 1'b1) acc++;
      if (i == 4) head = g_dut[0].instr;
      @(posedge clk); #1;
    end
    total++; if (acc != 3) begin bad++; $display("FAIL bp_accepts: got %0d want 3", acc); end
    total++; if (g_dut[0].rdy !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b want 0", g_dut[0].rdy); end
    total++; if (g_dut[0].instr !== head || head !== prog[0]) begin bad++; $display("FAIL bp_head_stable: got %h (earlier %h) want %h", g_dut[0].instr, head, prog[0]); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (g_dut[0].rdy !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop: got %b want 1", g_dut[0].rdy); end
    @(negedge clk);
    total++; if (g_dut[0].rdy !== 1'b0) begin bad++; $display("FAIL bp_one_more_accept: got ready %b want 0", g_dut[0].rdy); end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 30 && (g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size()) != 0; k++) @(negedge clk);
    total++; if (g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d left want 0", g_dut[0].q.size()); end
  endtask

  task automatic test_collision();
    logic [31:0] got [2];
    int n;
    n = 0;
    rsp_ready = 1'b1;
    fork
      begin
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = 32'h8;
        @(posedge clk); #1;
        load_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (g_dut[0].vld === 1'b1 && n < 2) begin got[n] = g_dut[0].instr; n++; end
        end
      end
    join
    total++;
    if (n != 2) begin bad++; $display("FAIL coll_count: got %0d want 2", n); end
    else begin
      if (got[0] !== prog[2]) begin bad++; $display("FAIL coll_old: got %h want %h", got[0], prog[2]); end
      total++;
      if (got[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL coll_new: got %h want deadbeef", got[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    logic [31:0] got [4];
    logic [31:0] want [4];
    int n;
    want = '{prog[0], prog[1], 32'hDEADBEEF, prog[3]};
    n = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'(i * 4);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    total++; if (g_dut[0].vld !== 1'b1) begin bad++; $display("FAIL rm_pending: got valid %b want 1", g_dut[0].vld); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (g_dut[0].vld !== 1'b0) begin bad++; $display("FAIL rm_valid_drop: got %b want 0", g_dut[0].vld); end
    total++; if (g_dut[0].rdy !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", g_dut[0].rdy); end
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    r0 = g_dut[0].n_rsp;
    repeat (6) @(negedge clk);
    total++; if (g_dut[0].n_rsp != r0) begin bad++; $display("FAIL rm_stale: got %0d responses want 0", g_dut[0].n_rsp - r0); end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          req_valid = 1'b1; req_addr = 32'(i * 4);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (g_dut[0].vld === 1'b1 && n < 4) begin got[n] = g_dut[0].instr; n++; end
        end
      end
    join
    total++;
    if (n != 4) begin bad++; $display("FAIL rm_count: got %0d want 4", n); end
    else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) total++;
        if (got[i] !== want[i]) begin bad++; $display("FAIL rm_store_%0d: got %h want %h", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_random();
    int a0[3];
    int p0[3];
    int r;
    for (int g = 0; g < 3; g++) begin a0[g] = 0; p0[g] = 0; end
    a0[0] = g_dut[0].n_acc; p0[0] = g_dut[0].n_rsp;
    a0[1] = g_dut[1].n_acc; p0[1] = g_dut[1].n_rsp;
    a0[2] = g_dut[2].n_acc; p0[2] = g_dut[2].n_rsp;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 19);
      if (r == 0)      req_addr = $urandom;
      else if (r == 1) req_addr = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      else             req_addr = {22'd0, 8'($urandom), 2'b00};
      load_en   = ($urandom_range(0, 7) == 0);
      load_addr = {22'd0, 8'($urandom), 2'b00};
      load_data = $urandom;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1; load_en = 1'b0;
    for (int k = 0; k < 40 && (g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size()) != 0; k++) @(negedge clk);
    total++; if (g_dut[0].n_acc - a0[0] != g_dut[0].n_rsp - p0[0] || g_dut[0].q.size() != 0) begin bad++; $display("FAIL rand_L2: got %0d rsp want %0d", g_dut[0].n_rsp - p0[0], g_dut[0].n_acc - a0[0]); end
    total++; if (g_dut[1].n_acc - a0[1] != g_dut[1].n_rsp - p0[1] || g_dut[1].q.size() != 0) begin bad++; $display("FAIL rand_L1: got %0d rsp want %0d", g_dut[1].n_rsp - p0[1], g_dut[1].n_acc - a0[1]); end
    total++; if (g_dut[2].n_acc - a0[2] != g_dut[2].n_rsp - p0[2] || g_dut[2].q.size() != 0) begin bad++; $display("FAIL rand_L4: got %0d rsp want %0d", g_dut[2].n_rsp - p0[2], g_dut[2].n_acc - a0[2]); end
    total++; if (g_dut[1].n_acc - a0[1] < 50) begin bad++; $display("FAIL rand_activity: got %0d accepts want >=50", g_dut[1].n_acc - a0[1]); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    init_store();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder at the far end of the fetch interface. It accepts instruction addresses from the fetch/PC side over a valid/ready request channel and holds a word-organised instruction store. It returns one 32-bit instruction per request, in order, over a valid/ready response channel after a fixed read latency. A side-band load port writes the store, for program loading from the testbench or the boot path.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit instruction words; must be a power of two, 16..4096.
- `LATENCY`, default 2: request-to-response latency in cycles; legal range 1..4.
- `NOP_INSTR`, default 32'h0000_0013: value returned on an erroneous access (`addi x0,x0,0`).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: a fetch address is presented.
- `req_ready` output 1: the responder can accept a request this cycle.
- `req_addr` input 32: byte address of the instruction (the PC value).
- `rsp_valid` output 1: a response is presented.
- `rsp_ready` input 1: the consumer accepts the response.
- `rsp_instr` output 32: instruction word for the oldest outstanding request.
- `rsp_error` output 1: the oldest response came from a misaligned or out-of-range address.
- `load_en` input 1: write strobe for the store.
- `load_addr` input 32: byte address for the load write.
- `load_data` input 32: word to write.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- An address is in range iff `addr[31:log2(DEPTH_WORDS)+2]` == 0.
- Request handshake: a request is accepted on a rising edge where `req_valid && req_ready`. `req_addr` is sampled only on that edge.
- Store read: the store is read at the acceptance edge. The data then travels through the remaining `LATENCY-1` pipeline stages and enters an in-order response FIFO.
- Error rule: if `req_addr[1:0]` != 0 or the address is out of range, the response carries `rsp_instr = NOP_INSTR` and `rsp_error = 1`. Otherwise it carries the stored word with `rsp_error = 0`.
- Outstanding counter:
  - `CAP = LATENCY+1`; the response FIFO holds at least `CAP` entries.
  - `outstanding` = requests accepted but not yet consumed by a response handshake.
  - It increments on request accept and decrements on `rsp_valid && rsp_ready`; when both occur on the same edge it is unchanged.
  - `req_ready = (outstanding < CAP)`, decoded from registered state only. It never depends combinationally on `req_valid` or `rsp_ready`.
- Response handshake: `rsp_valid` is high while the FIFO is non-empty. The head entry is popped on `rsp_valid && rsp_ready`.
- Response stability: while `rsp_valid && !rsp_ready`, `rsp_instr` and `rsp_error` hold stable.
- Ordering: responses are strictly in request order; there is no reordering or dropping.
- Load port:
  - When `load_en` is high with a word-aligned, in-range `load_addr`, the store word is written at that edge.
  - A misaligned or out-of-range load is ignored silently.
  - A load does not stall requests.
- Load/read collision: a request accepted on the same edge as a load to the same word returns the old contents. Requests accepted on later edges return the new data.
- Reset effects: reset clears the pipeline valid bits, the FIFO pointers and `outstanding`. The store contents are not reset.
- Reset mid-operation: any in-flight or queued responses are discarded and never emitted.

## Timing
- Reset values: `req_ready` = 1, `rsp_valid` = 0, `rsp_instr` = 0, `rsp_error` = 0.
- Latency: a request accepted at edge E with no older response pending asserts `rsp_valid` in the cycle following edge E+LATENCY-1. With `LATENCY=1`, the response appears in the cycle immediately after acceptance.
- Throughput: with `rsp_ready` tied high, one request is accepted every cycle indefinitely, and `outstanding` settles at `LATENCY`.
- Backpressure: with `rsp_ready` low, exactly `CAP` requests are accepted, then `req_ready` falls. `req_ready` rises in the cycle after the first response handshake.
- Reset assertion is asynchronous and takes effect immediately. Deassertion is sampled on `clk`, and the first request may be accepted on the first rising edge after release.

## Test plan
- Load words 0..3 with 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F. Then issue addresses 0,4,8,12 back to back with `rsp_ready` = 1. Required: the same four words in order, `rsp_error` = 0, the first `rsp_valid` `LATENCY` cycles after the first accept, and no bubbles.
- Request addresses 0x2, then 0x400 (`DEPTH_WORDS` = 256), then 0x4. Required: responses 32'h00000013/err=1, 32'h00000013/err=1, then the stored word/err=0.
- Hold `rsp_ready` = 0 and stream requests. Required: exactly `LATENCY+1` accepts, then `req_ready` = 0 with a stable head response. Raise `rsp_ready` for one cycle: one pop, then one further accept.
- On one edge, load 32'hDEADBEEF to address 8 and accept a request to 8; on the next edge, request 8 again. Required: the first response is the old value and the second is 32'hDEADBEEF.
- With 3 responses outstanding, pulse `reset` low mid-cycle. Required: `rsp_valid` drops immediately and `req_ready` = 1. No stale responses appear after release, and the store contents are preserved.
- Sweep `LATENCY` = 1 and 4 with random `req_valid`/`rsp_ready`. Required: the scoreboard shows in-order data, no loss or duplication, and `outstanding` never exceeds `LATENCY+1`.
